// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Misaligned/reserved trapping is enabled by LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        STORE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    function automatic logic is_sub(lsu_size_e s);
        return (s == SZ_BYTE) || (s == SZ_HALF);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = rdata[8*lane +: 8];
        h       = lane[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        st_data = wdata;
        unique case (size)
            SZ_BYTE: begin
                ld_data = {{24{~uns & b[7]}}, b};
                st_data = rdata;
                st_data[8*lane +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{~uns & h[15]}}, h};
                st_data = rdata;
                if (lane[1]) st_data[31:16] = wdata[15:0];
                else         st_data[15:0]  = wdata[15:0];
            end
            default: begin
                ld_data = rdata;
                st_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-only data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned and reserved accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_LIM = 32'(MEM_WORDS);

    lsu_state_e  state;
    lsu_size_e   size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic        uns_q;
    logic        err_q;
    logic        req_err;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    lsu_size_e   req_sz;

    assign req_sz = lsu_size_e'(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = (req_sz == SZ_HALF && req_addr[0])
                  || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)
                  || (req_sz == SZ_RSVD);
`else
    assign req_err = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = is_sub(size_q) ? merged_q : wdata_q;
    assign mem_we    = (state == STORE) && rst_n;

    lsu_align u_align (
        .size    (size_q),
        .uns     (uns_q),
        .lane    (addr_q[1:0]),
        .rdata   (mem_rdata),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_sz;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (is_sub(req_sz)) begin
                            state <= MERGE;
                        end else begin
                            state <= STORE;
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= ld_data;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                MERGE: begin
                    merged_q <= st_data;
                    state    <= STORE;
                end
                STORE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // we_q documents the latched direction; the FSM path already encodes it
    logic unused_we;
    assign unused_we = we_q;

    a_mem_range: assert property (
        @(posedge clk) mem_we |-> ({2'b00, mem_addr[31:2]} < MEM_LIM)
    );

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the word-addressed data memory. Accepts one byte, halfword or word load/store request at a time and translates it into word-aligned memory accesses. Loads extract the addressed lane and sign- or zero-extend it. Sub-word stores use a read-modify-write sequence, because the data memory only writes whole words.

## Interface
- MEM_WORDS, 64: data memory depth in words; only the mem_addr width check depends on it.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend loads when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores; held until the next rsp_valid.
- rsp_err  out  1  misaligned/reserved access; valid with rsp_valid.
- mem_addr  out  32  {addr_q[31:2], 2'b00}.
- mem_wdata  out  32  word to write.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  32  combinational read data for mem_addr.

## Operation
- On acceptance, latch addr, size, we, unsigned and wdata. Latched values are stable while busy.
- States and transitions:
  - IDLE: error -> RESP; load -> LOAD; word store -> STORE; sub-word store -> MERGE.
  - LOAD: capture mem_rdata, extract the lane, extend it -> RESP.
  - MERGE: capture mem_rdata and replace the addressed byte lane(s) with wdata[7:0] or wdata[15:0] -> STORE.
  - STORE: mem_we=1, mem_wdata = merged word (sub-word) or latched wdata (word) -> RESP.
  - RESP: rsp_valid=1 -> IDLE.
- Lanes are little-endian:
  - Byte lane = addr[1:0]; data[8*k+7:8*k].
  - Half lane = addr[1]; data[16*h+15:16*h].
- Sign extension uses the lane MSB when req_unsigned=0.
- mem_we = (state==STORE) && rst_n. A write is never issued in a reset cycle.
- A request presented while busy waits, because req_ready=0. There is no request queue.
- rsp has no backpressure. The consumer must take rsp_valid in the cycle it appears.

## Timing
- Cycle 0 is the acceptance edge.
- rsp_valid is asserted:
  - error: cycle 1;
  - load and word store: cycle 2;
  - sub-word store: cycle 3.
- Memory is updated at the end of the STORE cycle. A load issued after rsp_valid observes the new data.
- Maximum throughput: one request per 3 cycles (load/word) or 4 cycles (sub-word store).
- Reset values:
  - state IDLE, req_ready 1;
  - rsp_valid 0, rsp_rdata 0, rsp_err 0;
  - mem_we 0, mem_wdata 0, mem_addr 0;
  - all latches 0.
- Reset in any state abandons the operation and produces no response. Reset during MERGE leaves memory unmodified by this block.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size 11 goes IDLE -> RESP with rsp_err=1, rsp_rdata=0 and no memory access.
- Undefined:
  - Offending low address bits are ignored: half uses only addr[1]; word uses no low bits.
  - Size 11 is treated as word.
  - rsp_err is tied to 0.

## Structure
- Package lsu_pkg holds:
  - lsu_size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - lsu_state_e (IDLE, LOAD, MERGE, STORE, RESP).
- Sub-module lsu_align is purely combinational and does both lane jobs:
  - extract plus sign/zero extend for loads;
  - lane merge for stores.
- The FSM and all registers stay in load_store_unit.

## Test plan
- Preload word 0x8899AABB at 0x20, then load:
  - LB 0x21 -> 0xFFFFFFAA; LBU 0x21 -> 0x000000AA;
  - LH 0x22 -> 0xFFFF8899; LHU 0x22 -> 0x00008899;
  - LW 0x20 -> 0x8899AABB;
  - each with rsp_valid at cycle 2.
- SB 0x21 with wdata 0x12345655 -> memory 0x889955BB. mem_we high for exactly one cycle (cycle 2); rsp_valid at cycle 3.
- SH 0x22 with wdata 0xFFFF1234 -> memory 0x1234AABB. Then SW 0x20 with wdata 0xDEADBEEF -> memory 0xDEADBEEF, rsp at cycle 2.
- SW 0x22:
  - with LSU_MISALIGN_TRAP_EN -> rsp_err=1 at cycle 1, mem_we never high, memory unchanged;
  - without it -> word written at 0x20, rsp_err=0.
- Hold req_valid for three back-to-back loads -> req_ready low while busy, each request accepted once, three rsp_valid pulses, data in order.
- Assert rst_n=0 during MERGE of SB 0x21 -> no mem_we and no rsp_valid. After release, req_ready=1 and all outputs are at their reset values.
